// File: rtl/blit_fbfetch_pkg.sv
// Shared types and constants for the Blit framebuffer fetch engine.
// Frame geometry defaults and RAM port widths live here.
package blit_fbfetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int STRB_W = 2;

   localparam int H_PIXELS   = 800;
   localparam int DEF_HWORDS = 50;
   localparam int DEF_VLINES = 1024;

endpackage

// File: rtl/blit_wfifo.sv
// Synchronous DEPTH x 16 word FIFO with flush; DEPTH is a power of two
// so pointers wrap for free.
module blit_wfifo
   import blit_fbfetch_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int FCW = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [FCW-1:0]    count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FCW'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count + FCW'(do_push) - FCW'(do_pop);
      end
   end

endmodule

// File: rtl/blit_fbfetch.sv
// Framebuffer fetch: reads 1bpp words from RAM into a FIFO and shifts
// them out one pixel per pix_req, MSB first.
module blit_fbfetch
   import blit_fbfetch_pkg::*;
#(
   parameter int HWORDS = DEF_HWORDS,
   parameter int VLINES = DEF_VLINES,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic              vid_start,
   input  logic              pix_req,
   output logic              pix_out,
   output logic              underflow,
   output logic              ram_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [STRB_W-1:0] ram_wstrb,
   output logic              ram_we,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int TOTAL = HWORDS * VLINES;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int FCW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(TOTAL);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     wcnt_q, wcnt_d, wcnt_inc;
   logic              drop_q, drop_d;

   logic              push, pop, empty, full, room;
   logic [FCW-1:0]    fcount, fill_next;
   logic [DATA_W-1:0] fdata;
   logic [15:0]       sh_q;
   logic [4:0]        bits_q;

   assign ram_req   = (state_q == S_REQ);
   assign ram_addr  = addr_q;
   assign ram_wdata = '0;
   assign ram_wstrb = '0;
   assign ram_we    = 1'b0;

   assign push = (state_q == S_WAIT) && ram_ack && !drop_q && !vid_start;
   assign pop  = pix_req && !vid_start && (bits_q == 5'd0) && !empty;

   // Room is judged on the occupancy after this cycle's push/pop.
   assign fill_next = fcount + FCW'(push) - FCW'(pop);
   assign room      = (fill_next < FCW'(DEPTH));
   assign wcnt_inc  = wcnt_q + CW'(1);

   blit_wfifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (vid_start),
      .din   (ram_rdata),
      .dout  (fdata),
      .empty (empty),
      .full  (full),
      .count (fcount)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wcnt_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      drop_d  = drop_q;
      if (vid_start) begin
         addr_d  = {fb_base[ADDR_W-1:1], 1'b0};
         wcnt_d  = '0;
         drop_d  = 1'b0;
         state_d = S_REQ;
         // An ack landing with the restart is simply absorbed.
         if (state_q == S_WAIT && !ram_ack) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
               if (ram_ack) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     addr_d = addr_q + ADDR_W'(2);
                     wcnt_d = wcnt_inc;
                     if (wcnt_inc == LAST) state_d = S_IDLE;
                     else if (room)        state_d = S_REQ;
                     else                  state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: if (!full) state_d = S_REQ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q      <= '0;
         bits_q    <= '0;
         pix_out   <= 1'b0;
         underflow <= 1'b0;
      end else if (vid_start) begin
         sh_q      <= '0;
         bits_q    <= '0;
         pix_out   <= 1'b0;
         underflow <= 1'b0;
      end else if (pix_req) begin
         if (bits_q != 5'd0) begin
            pix_out <= sh_q[15];
            sh_q    <= {sh_q[14:0], 1'b0};
            bits_q  <= bits_q - 5'd1;
         end else if (!empty) begin
            pix_out <= fdata[15];
            sh_q    <= {fdata[14:0], 1'b0};
            bits_q  <= 5'd15;
         end else begin
            pix_out   <= 1'b0;
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_blit_fbfetch.sv
// Scoreboard bench for blit_fbfetch: expected addresses and pixels are
// queued by the stimulus and compared by independent monitors.
module tb_blit_fbfetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [17:0] a_base = '0, b_base = '0;
   logic        a_vs = 0, a_pr = 0, b_vs = 0, b_pr = 0;
   logic        a_pix, a_uf, a_req, a_we, b_pix, b_uf, b_req, b_we;
   logic [17:0] a_addr, b_addr;
   logic [15:0] a_wd, b_wd;
   logic [1:0]  a_ws, b_ws;
   logic        a_ack = 0, b_ack = 0;
   logic [15:0] a_rd = '0, b_rd = '0;

   int n_tot = 0;
   int n_pass = 0;

   logic [17:0] a_eaddr [$];
   logic [17:0] b_eaddr [$];
   logic        a_epix [$];
   logic [15:0] a_rdq [$];
   logic [15:0] b_rdq [$];
   int          a_lat = 1;
   int          a_cd = 0;
   logic [15:0] a_pend = '0;
   logic        a_pr_d;

   blit_fbfetch u_a (
      .clk(clk), .rst(rst), .fb_base(a_base), .vid_start(a_vs),
      .pix_req(a_pr), .pix_out(a_pix), .underflow(a_uf),
      .ram_req(a_req), .ram_addr(a_addr), .ram_wdata(a_wd),
      .ram_wstrb(a_ws), .ram_we(a_we), .ram_ack(a_ack), .ram_rdata(a_rd)
   );

   blit_fbfetch #(.HWORDS(2), .VLINES(2)) u_b (
      .clk(clk), .rst(rst), .fb_base(b_base), .vid_start(b_vs),
      .pix_req(b_pr), .pix_out(b_pix), .underflow(b_uf),
      .ram_req(b_req), .ram_addr(b_addr), .ram_wdata(b_wd),
      .ram_wstrb(b_ws), .ram_we(b_we), .ram_ack(b_ack), .ram_rdata(b_rd)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] pop_a();
      if (a_rdq.size() > 0) return a_rdq.pop_front();
      return 16'h0000;
   endfunction

   function automatic logic [15:0] pop_b();
      if (b_rdq.size() > 0) return b_rdq.pop_front();
      return 16'h0000;
   endfunction

   task automatic push_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) a_epix.push_back(w[i]);
   endtask

   // RAM model A with programmable ack latency
   always @(posedge clk) begin
      a_ack <= 1'b0;
      if (a_cd == 1) begin
         a_ack <= 1'b1;
         a_rd  <= a_pend;
      end
      if (a_cd > 0) a_cd <= a_cd - 1;
      if (a_req) begin
         if (a_lat == 1) begin
            a_ack <= 1'b1;
            a_rd  <= pop_a();
         end else begin
            a_cd   <= a_lat - 1;
            a_pend <= pop_a();
         end
      end
   end

   always @(posedge clk) begin
      b_ack <= b_req;
      if (b_req) b_rd <= pop_b();
   end

   always @(posedge clk or posedge rst) begin
      if (rst) a_pr_d <= 1'b0;
      else     a_pr_d <= a_pr && !a_vs;
   end

   always @(negedge clk) begin
      if (!rst && a_req) begin
         if (a_eaddr.size() == 0) chk("a_unexpected_req", 1, 0);
         else chk("a_req_addr", 32'(a_addr), 32'(a_eaddr.pop_front()));
      end
      if (!rst && b_req) begin
         if (b_eaddr.size() == 0) chk("b_unexpected_req", 1, 0);
         else chk("b_req_addr", 32'(b_addr), 32'(b_eaddr.pop_front()));
      end
      if (a_pr_d && a_epix.size() > 0)
         chk("a_pix", 32'(a_pix), 32'(a_epix.pop_front()));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pix", 32'(a_pix), 0);
      chk("rst_uf", 32'(a_uf), 0);
      chk("rst_req", 32'(a_req), 0);
      chk("rst_addr", 32'(a_addr), 0);
      chk("rst_ties", 32'({a_we, a_ws, a_wd}), 0);

      // Underflow without any frame started
      a_pr = 1'b1;
      @(negedge clk);
      a_pr = 1'b0;
      chk("t4_uf_set", 32'(a_uf), 1);
      chk("t4_pix_zero", 32'(a_pix), 0);

      // Fill until FIFO full, pix_req low
      a_rdq = '{16'hA5F0, 16'h8001, 16'h1111, 16'h2222,
                16'h3333, 16'h4444, 16'h5555, 16'h6666};
      for (int i = 0; i < 8; i++) a_eaddr.push_back(18'h00100 + 18'(2 * i));
      a_base = 18'h00100;
      a_vs = 1'b1;
      @(negedge clk);
      a_vs = 1'b0;
      chk("t4_uf_clear", 32'(a_uf), 0);
      repeat (40) @(negedge clk);
      chk("t1_reqs_done", a_eaddr.size(), 0);

      // Serialise two words with continuous pix_req
      push_word(16'hA5F0);
      push_word(16'h8001);
      a_eaddr.push_back(18'h00110);
      a_eaddr.push_back(18'h00112);
      a_pr = 1'b1;
      repeat (32) @(negedge clk);
      a_pr = 1'b0;
      repeat (10) @(negedge clk);
      chk("t2_pix_done", a_epix.size(), 0);
      chk("t2_refills", a_eaddr.size(), 0);
      chk("t2_uf", 32'(a_uf), 0);

      // Restart while a read is outstanding; DEAD must be discarded
      a_lat = 3;
      a_eaddr.delete();
      a_eaddr.push_back(18'h01000);
      for (int i = 0; i < 8; i++) a_eaddr.push_back(18'h02000 + 18'(2 * i));
      a_rdq = '{16'hDEAD, 16'h1234};
      a_base = 18'h01000;
      a_vs = 1'b1;
      @(negedge clk);
      a_vs = 1'b0;
      @(negedge clk);
      a_base = 18'h02000;
      a_vs = 1'b1;
      @(negedge clk);
      a_vs = 1'b0;
      repeat (60) @(negedge clk);
      chk("t5_reqs_done", a_eaddr.size(), 0);
      push_word(16'h1234);
      a_eaddr.push_back(18'h02010);
      a_pr = 1'b1;
      repeat (16) @(negedge clk);
      a_pr = 1'b0;
      repeat (20) @(negedge clk);
      chk("t5_pix_done", a_epix.size(), 0);
      chk("t5_refill", a_eaddr.size(), 0);
      chk("t5_uf", 32'(a_uf), 0);

      // Reset mid-frame with words buffered
      a_lat = 1;
      a_eaddr.delete();
      for (int i = 0; i < 16; i++) a_eaddr.push_back(18'h00300 + 18'(2 * i));
      a_rdq = '{16'hFFFF};
      a_base = 18'h00300;
      a_vs = 1'b1;
      @(negedge clk);
      a_vs = 1'b0;
      repeat (2) @(negedge clk);
      a_epix.push_back(1'b1);
      a_pr = 1'b1;
      @(negedge clk);
      a_pr = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_pix", 32'(a_pix), 0);
      chk("t6_uf", 32'(a_uf), 0);
      chk("t6_req", 32'(a_req), 0);
      chk("t6_addr", 32'(a_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      a_eaddr.delete();
      chk("t6_pix_seen", a_epix.size(), 0);
      repeat (20) @(negedge clk);
      chk("t6_idle_req", 32'(a_req), 0);

      // Small frame wraps the address space and then stops
      b_eaddr = '{18'h3FFFC, 18'h3FFFE, 18'h00000, 18'h00002};
      b_base = 18'h3FFFC;
      b_vs = 1'b1;
      @(negedge clk);
      b_vs = 1'b0;
      repeat (20) @(negedge clk);
      chk("t3_frame", b_eaddr.size(), 0);
      repeat (20) @(negedge clk);
      b_eaddr = '{18'h00010, 18'h00012, 18'h00014, 18'h00016};
      b_base = 18'h00011;
      b_vs = 1'b1;
      @(negedge clk);
      b_vs = 1'b0;
      repeat (20) @(negedge clk);
      chk("t3_second_frame", b_eaddr.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
